pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage mips32 pipeline. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC: load-use bubbles, taken-branch flushes resolved in MEM, and freezes during data-memory wait states via a req/ack handshake. The PC, pipeline registers and data-memory interface consume its outputs directly.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3; 2 when forwarding is disabled)
MEM_TIMEOUT, 15, max wait cycles on dmem_ack before abort (1..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
memread_ex  in  1  instruction in EX is a load
destreg_ex  in  5  destination register of instruction in EX
rs_id  in  5  rs field of instruction in ID
rt_id  in  5  rt field of instruction in ID
uses_rt_id  in  1  ID instruction reads rt
branch_mem  in  1  instruction in MEM is a conditional branch
zero_mem  in  1  ALU zero flag latched in EX/MEM
memop_mem  in  1  instruction in MEM is a load or store
dmem_ack  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear
idex_flush  out  1  ID/EX clear (bubble)
exmem_hold  out  1  EX/MEM hold current contents
exmem_flush  out  1  EX/MEM clear
pc_src_branch  out  1  PC selects branch target from EX/MEM
dmem_req  out  1  data memory request
mem_timeout_err  out  1  registered one-cycle abort pulse
state_out  out  2  current state: 0 RUN, 1 LDSTALL, 2 MEMWAIT, 3 FLUSH

Behaviour:
- Outputs are combinational from the registered state/counters and current inputs; mem_timeout_err is registered.
- Reset (rst high at edge): state RUN, stall_cnt=0, wait_cnt=0, mem_timeout_err=0. Defaults in RUN with no event: pc_write=1, ifid_write=1, all flush/hold/src/req=0.
- hazard = memread_ex & destreg_ex!=0 & (destreg_ex==rs_id | (uses_rt_id & destreg_ex==rt_id)).
- taken = branch_mem & zero_mem.
- dmem_req = memop_mem in RUN, LDSTALL and MEMWAIT.
- RUN priority, highest first:
  - memop_mem & !dmem_ack: freeze (pc_write=0, ifid_write=0, exmem_hold=1, no flushes); next MEMWAIT, wait_cnt=1.
  - taken: pc_src_branch=1, pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1; next FLUSH.
  - hazard: pc_write=0, ifid_write=0, idex_flush=1. Next is LDSTALL with stall_cnt=1 if LOAD_STALL_CYCLES>1, else RUN.
- LDSTALL: same outputs as a hazard cycle; stall_cnt increments; when stall_cnt==LOAD_STALL_CYCLES-1, next RUN. A memory wait in LDSTALL takes priority: go to MEMWAIT and restart the bubble count afterwards in RUN.
- MEMWAIT: freeze outputs.
  - dmem_ack=1: release this cycle (normal RUN outputs, but hazard/taken are not acted on); next RUN, wait_cnt=0.
  - wait_cnt==MEM_TIMEOUT without ack: mem_timeout_err pulses next cycle; exmem_flush=1; next RUN.
- FLUSH: one cycle with ifid_flush=1 and idex_flush=1 (covers the fetch issued alongside the redirect); pc_write=1; next RUN.
- Simultaneous taken & hazard in RUN: branch wins, no bubble.
- rst mid-MEMWAIT or mid-LDSTALL: abort immediately to RUN, no error pulse.

Optional Feature:
HAZARD_STATS_EN defined:
- Adds outputs stall_cycles[15:0], flush_events[15:0] and timeout_events[7:0].
- Counters saturate, clear on rst, and increment per freeze/bubble cycle, per taken branch and per timeout.

HAZARD_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle inputs -> state_out=0, pc_write=1, ifid_write=1, all flush/hold/req=0, mem_timeout_err=0.
- memread_ex=1, destreg_ex=8, rs_id=8 for one cycle, LOAD_STALL_CYCLES=1 -> exactly one cycle of pc_write=0 and idex_flush=1, then RUN. With LOAD_STALL_CYCLES=2 -> two such cycles, state_out 0→1→0. destreg_ex=0 -> no stall.
- branch_mem=1, zero_mem=1 -> pc_src_branch=1 and three flushes in that cycle, state FLUSH next cycle with ifid/idex flush, then RUN. zero_mem=0 -> no action.
- memop_mem=1, dmem_ack low 3 cycles then high -> dmem_req=1 for 4 cycles, exmem_hold=1 for the first 3, state MEMWAIT for 3 cycles, then RUN.
- MEM_TIMEOUT=4, dmem_ack never high -> after 4 MEMWAIT cycles, exmem_flush=1, mem_timeout_err=1 for exactly one cycle, then RUN.
- taken branch and load-use hazard in the same cycle -> flush only, pc_write=1. rst asserted in 2nd MEMWAIT cycle -> RUN next edge, no error pulse.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake/control bundle between the mips32 pipeline datapath and its hazard controller.
// Optional counters appear only when HAZARD_STATS_EN is defined.
interface pipeline_hazard_ctrl_if;
    logic       memread_ex;
    logic [4:0] destreg_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rt_id;
    logic       branch_mem;
    logic       zero_mem;
    logic       memop_mem;
    logic       dmem_ack;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_hold;
    logic       exmem_flush;
    logic       pc_src_branch;
    logic       dmem_req;
    logic       mem_timeout_err;
    logic [1:0] state_out;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
    logic [7:0]  timeout_events;
`endif

    modport master (
        output memread_ex, destreg_ex, rs_id, rt_id, uses_rt_id,
               branch_mem, zero_mem, memop_mem, dmem_ack,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold,
               exmem_flush, pc_src_branch, dmem_req, mem_timeout_err, state_out
`ifdef HAZARD_STATS_EN
        , input stall_cycles, flush_events, timeout_events
`endif
    );

    modport slave (
        input  memread_ex, destreg_ex, rs_id, rt_id, uses_rt_id,
               branch_mem, zero_mem, memop_mem, dmem_ack,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold,
               exmem_flush, pc_src_branch, dmem_req, mem_timeout_err, state_out
`ifdef HAZARD_STATS_EN
        , output stall_cycles, flush_events, timeout_events
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage mips32 pipeline; controls are combinational from state, timeout pulse registered.
// Memory wait states freeze the pipe until dmem_ack or MEM_TIMEOUT; HAZARD_STATS_EN adds saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic hazard, taken, mem_stall;
    logic pc_write, ifid_write, ifid_flush, idex_flush;
    logic exmem_hold, exmem_flush, pc_src_branch, dmem_req;

    assign hazard = hz.memread_ex && (hz.destreg_ex != 5'd0) &&
                    ((hz.destreg_ex == hz.rs_id) ||
                     (hz.uses_rt_id && (hz.destreg_ex == hz.rt_id)));
    assign taken     = hz.branch_mem && hz.zero_mem;
    assign mem_stall = hz.memop_mem && !hz.dmem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 2'd0;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = 1'b0;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        exmem_flush   = 1'b0;
        pc_src_branch = 1'b0;
        dmem_req      = 1'b0;
        case (state_q)
            ST_RUN, ST_LDSTALL: begin
                dmem_req = hz.memop_mem;
                if (mem_stall) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    exmem_hold  = 1'b1;
                    state_d     = ST_MEMWAIT;
                    wait_cnt_d  = 8'd1;
                    stall_cnt_d = 2'd0;
                end else if (state_q == ST_LDSTALL) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_flush  = 1'b1;
                    stall_cnt_d = stall_cnt_q + 2'd1;
                    if (stall_cnt_q == 2'(LOAD_STALL_CYCLES - 1)) begin
                        state_d     = ST_RUN;
                        stall_cnt_d = 2'd0;
                    end
                end else if (taken) begin
                    // Branch resolved in MEM beats any load-use bubble: the younger instructions die anyway.
                    pc_src_branch = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    exmem_flush   = 1'b1;
                    state_d       = ST_FLUSH;
                end else if (hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d     = ST_LDSTALL;
                        stall_cnt_d = 2'd1;
                    end
                end
            end
            ST_MEMWAIT: begin
                dmem_req = hz.memop_mem;
                if (hz.dmem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
                    // Abort drops the stuck access instead of holding it.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    exmem_flush = 1'b1;
                    err_d       = 1'b1;
                    state_d     = ST_RUN;
                    wait_cnt_d  = 8'd0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign hz.pc_write        = pc_write;
    assign hz.ifid_write      = ifid_write;
    assign hz.ifid_flush      = ifid_flush;
    assign hz.idex_flush      = idex_flush;
    assign hz.exmem_hold      = exmem_hold;
    assign hz.exmem_flush     = exmem_flush;
    assign hz.pc_src_branch   = pc_src_branch;
    assign hz.dmem_req        = dmem_req;
    assign hz.mem_timeout_err = err_q;
    assign hz.state_out       = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] flush_events_q;
    logic [7:0]  timeout_events_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q   <= 16'd0;
            flush_events_q   <= 16'd0;
            timeout_events_q <= 8'd0;
        end else begin
            if (!pc_write && (stall_cycles_q != 16'hFFFF))
                stall_cycles_q <= stall_cycles_q + 16'd1;
            if (pc_src_branch && (flush_events_q != 16'hFFFF))
                flush_events_q <= flush_events_q + 16'd1;
            if (err_d && (timeout_events_q != 8'hFF))
                timeout_events_q <= timeout_events_q + 8'd1;
        end
    end

    assign hz.stall_cycles   = stall_cycles_q;
    assign hz.flush_events   = flush_events_q;
    assign hz.timeout_events = timeout_events_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a uses LOAD_STALL_CYCLES=1/MEM_TIMEOUT=4, dut_b uses 2/15; both see identical stimulus.
// Output vector order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, exmem_flush, pc_src_branch, dmem_req, mem_timeout_err, state[1:0].
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       memread_ex;
    logic [4:0] destreg_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rt_id;
    logic       branch_mem;
    logic       zero_mem;
    logic       memop_mem;
    logic       dmem_ack;
    int         passed = 0;
    int         total  = 0;

    localparam logic [10:0] IDLE       = 11'b11000000000;
    localparam logic [10:0] HZ_RUN     = 11'b00010000000;
    localparam logic [10:0] HZ_LD      = 11'b00010000001;
    localparam logic [10:0] TAKEN      = 11'b11110110000;
    localparam logic [10:0] FLUSH      = 11'b11110000011;
    localparam logic [10:0] MEMHIT     = 11'b11000001000;
    localparam logic [10:0] FRZ_RUN    = 11'b00001001000;
    localparam logic [10:0] FRZ_LD     = 11'b00001001001;
    localparam logic [10:0] FRZ_MW     = 11'b00001001010;
    localparam logic [10:0] FRZ_MW_NR  = 11'b00001000010;
    localparam logic [10:0] REL_MW     = 11'b11000001010;
    localparam logic [10:0] REL_MW_NR  = 11'b11000000010;
    localparam logic [10:0] ABORT      = 11'b00000101010;
    localparam logic [10:0] ERR_IDLE   = 11'b11000000100;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if ifa ();
    pipeline_hazard_ctrl_if ifb ();

    assign ifa.memread_ex = memread_ex;
    assign ifa.destreg_ex = destreg_ex;
    assign ifa.rs_id      = rs_id;
    assign ifa.rt_id      = rt_id;
    assign ifa.uses_rt_id = uses_rt_id;
    assign ifa.branch_mem = branch_mem;
    assign ifa.zero_mem   = zero_mem;
    assign ifa.memop_mem  = memop_mem;
    assign ifa.dmem_ack   = dmem_ack;
    assign ifb.memread_ex = memread_ex;
    assign ifb.destreg_ex = destreg_ex;
    assign ifb.rs_id      = rs_id;
    assign ifb.rt_id      = rt_id;
    assign ifb.uses_rt_id = uses_rt_id;
    assign ifb.branch_mem = branch_mem;
    assign ifb.zero_mem   = zero_mem;
    assign ifb.memop_mem  = memop_mem;
    assign ifb.dmem_ack   = dmem_ack;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (ifa)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(15)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (ifb)
    );

    wire [10:0] obs_a = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_flush,
                         ifa.exmem_hold, ifa.exmem_flush, ifa.pc_src_branch, ifa.dmem_req,
                         ifa.mem_timeout_err, ifa.state_out};
    wire [10:0] obs_b = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_flush,
                         ifb.exmem_hold, ifb.exmem_flush, ifb.pc_src_branch, ifb.dmem_req,
                         ifb.mem_timeout_err, ifb.state_out};

    task automatic clear_inputs();
        memread_ex = 1'b0;
        destreg_ex = 5'd0;
        rs_id      = 5'd0;
        rt_id      = 5'd0;
        uses_rt_id = 1'b0;
        branch_mem = 1'b0;
        zero_mem   = 1'b0;
        memop_mem  = 1'b0;
        dmem_ack   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] ea, input logic [10:0] eb);
        @(negedge clk);
        total++;
        assert (obs_a === ea) passed++;
        else $error("FAIL %s/a: got %b expected %b", tag, obs_a, ea);
        total++;
        assert (obs_b === eb) passed++;
        else $error("FAIL %s/b: got %b expected %b", tag, obs_b, eb);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset", IDLE, IDLE);
        step();

        memread_ex = 1'b1; destreg_ex = 5'd8; rs_id = 5'd8;
        check("lu_rs", HZ_RUN, HZ_RUN);
        step();
        clear_inputs();
        check("lu_rs_1", IDLE, HZ_LD);
        step();
        check("lu_rs_2", IDLE, IDLE);
        step();

        memread_ex = 1'b1; destreg_ex = 5'd0; rs_id = 5'd0;
        check("lu_r0", IDLE, IDLE);
        step();
        destreg_ex = 5'd5; rs_id = 5'd1; rt_id = 5'd5; uses_rt_id = 1'b0;
        check("lu_rt_unused", IDLE, IDLE);
        step();
        uses_rt_id = 1'b1;
        check("lu_rt", HZ_RUN, HZ_RUN);
        step();
        clear_inputs();
        check("lu_rt_1", IDLE, HZ_LD);
        step();

        branch_mem = 1'b1; zero_mem = 1'b0;
        check("br_nt", IDLE, IDLE);
        step();
        zero_mem = 1'b1;
        check("br_t", TAKEN, TAKEN);
        step();
        clear_inputs();
        check("br_flush", FLUSH, FLUSH);
        step();
        check("br_done", IDLE, IDLE);
        step();

        branch_mem = 1'b1; zero_mem = 1'b1; memread_ex = 1'b1; destreg_ex = 5'd3; rs_id = 5'd3;
        check("br_lu", TAKEN, TAKEN);
        step();
        clear_inputs();
        check("br_lu_flush", FLUSH, FLUSH);
        step();
        check("br_lu_done", IDLE, IDLE);
        step();

        memop_mem = 1'b1; dmem_ack = 1'b1;
        check("mem_hit", MEMHIT, MEMHIT);
        step();
        dmem_ack = 1'b0;
        check("mw0", FRZ_RUN, FRZ_RUN);
        step();
        check("mw1", FRZ_MW, FRZ_MW);
        step();
        check("mw2", FRZ_MW, FRZ_MW);
        step();
        dmem_ack = 1'b1;
        check("mw_rel", REL_MW, REL_MW);
        step();
        clear_inputs();
        check("mw_done", IDLE, IDLE);
        step();

        memop_mem = 1'b1; dmem_ack = 1'b0;
        check("to0", FRZ_RUN, FRZ_RUN);
        step();
        for (int i = 0; i < 3; i++) begin
            check("to_wait", FRZ_MW, FRZ_MW);
            step();
        end
        check("to_abort", ABORT, FRZ_MW);
        step();
        memop_mem = 1'b0;
        check("to_err", ERR_IDLE, FRZ_MW_NR);
        step();
        dmem_ack = 1'b1;
        check("to_err_clr", IDLE, REL_MW_NR);
        step();
        clear_inputs();
        check("to_done", IDLE, IDLE);
        step();

        memread_ex = 1'b1; destreg_ex = 5'd9; rt_id = 5'd9; uses_rt_id = 1'b1; rs_id = 5'd2;
        check("ld_mw0", HZ_RUN, HZ_RUN);
        step();
        clear_inputs();
        memop_mem = 1'b1;
        check("ld_mw1", FRZ_RUN, FRZ_LD);
        step();
        dmem_ack = 1'b1;
        check("ld_mw_rel", REL_MW, REL_MW);
        step();
        clear_inputs();
        check("ld_mw_done", IDLE, IDLE);
        step();

        memop_mem = 1'b1;
        check("rmw0", FRZ_RUN, FRZ_RUN);
        step();
        check("rmw1", FRZ_MW, FRZ_MW);
        step();
        rst = 1'b1;
        check("rmw2", FRZ_MW, FRZ_MW);
        step();
        rst = 1'b0;
        clear_inputs();
        check("rmw_rst", IDLE, IDLE);
        step();
        check("rmw_noerr", IDLE, IDLE);
        step();

        memread_ex = 1'b1; destreg_ex = 5'd8; rs_id = 5'd8;
        check("rld0", HZ_RUN, HZ_RUN);
        step();
        clear_inputs();
        rst = 1'b1;
        check("rld1", IDLE, HZ_LD);
        step();
        rst = 1'b0;
        check("rld_rst", IDLE, IDLE);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
